// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
package ifu_pkg;

  // Fetch FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4,
    FAULT = 3'd5
  } ifu_state_t;

  // Reason recorded when the unit enters FAULT
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ACCESS   = 2'd1,
    CAUSE_TIMEOUT  = 2'd2,
    CAUSE_MISALIGN = 2'd3
  } fault_cause_t;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int unsigned IFU_TIMEOUT  = 255;

  // A fetch target is usable only when it is word aligned
  function automatic logic ifu_pc_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit. Issues one imem read
// per instruction, hands the word to decode, then waits for write-back to
// supply the next PC. Any fault parks the unit until reset.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int unsigned TIMEOUT  = IFU_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic [31:0] real_ins,
  output logic        ifu_valid,
  input  logic        idu_ready,
  output logic [31:0] pc,
  input  logic        wb_valid,
  input  logic [31:0] wb_next_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  // Counter value during the last WAIT cycle allowed before a timeout fault
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  ifu_state_t   state_r, state_next_s;
  fault_cause_t cause_r, cause_next_s;
  logic [31:0]  pc_r, pc_next_s;
  logic [31:0]  ins_r, ins_next_s;
  logic [7:0]   cnt_r, cnt_next_s;

  // State, PC, instruction, counter and cause registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      ins_r   <= 32'h0000_0000;
      cnt_r   <= 8'd0;
      cause_r <= CAUSE_NONE;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      ins_r   <= ins_next_s;
      cnt_r   <= cnt_next_s;
      cause_r <= cause_next_s;
    end
  end

  // Next-state and datapath update; inputs outside their owning state are ignored
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    ins_next_s   = ins_r;
    cnt_next_s   = cnt_r;
    cause_next_s = cause_r;
    case (state_r)
      IDLE: begin
        state_next_s = REQ;
      end
      REQ: begin
        if (imem_req_ready) begin
          state_next_s = WAIT;
          cnt_next_s   = 8'd0;
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT: begin
        // Saturating so a large TIMEOUT can never wrap back to zero
        if (cnt_r == 8'hFF) begin
          cnt_next_s = cnt_r;
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
        // A response arriving on the final allowed cycle still wins
        if (imem_rsp_valid && !imem_rsp_err) begin
          ins_next_s   = imem_rsp_data;
          state_next_s = HOLD;
        end else if (imem_rsp_valid) begin
          state_next_s = FAULT;
          cause_next_s = CAUSE_ACCESS;
        end else if (cnt_r >= CNT_LAST) begin
          state_next_s = FAULT;
          cause_next_s = CAUSE_TIMEOUT;
        end else begin
          state_next_s = WAIT;
        end
      end
      HOLD: begin
        if (idu_ready) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = HOLD;
        end
      end
      EXEC: begin
        if (wb_valid) begin
          if (ifu_pc_aligned(wb_next_pc)) begin
            pc_next_s    = wb_next_pc;
            state_next_s = REQ;
          end else begin
            state_next_s = FAULT;
            cause_next_s = CAUSE_MISALIGN;
          end
        end else begin
          state_next_s = EXEC;
        end
      end
      FAULT: begin
        state_next_s = FAULT;
      end
      default: begin
        // Corrupted state encoding: park safely
        state_next_s = FAULT;
      end
    endcase
  end

  // Outputs come straight from registers or a decode of the state register
  assign imem_req_valid = (state_r == REQ);
  assign imem_req_addr  = pc_r;
  assign ifu_valid      = (state_r == HOLD);
  assign real_ins       = ins_r;
  assign pc             = pc_r;
  assign fetch_fault    = (state_r == FAULT);
  assign fault_cause    = cause_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed stimulus with an abstract fetch model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_ifu_fetch;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        imem_rsp_err   = 1'b0;
  logic [31:0] real_ins;
  logic        ifu_valid;
  logic        idu_ready = 1'b0;
  logic [31:0] pc;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_next_pc = 32'h0;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(32'h8000_0000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .real_ins(real_ins), .ifu_valid(ifu_valid), .idu_ready(idu_ready),
    .pc(pc), .wb_valid(wb_valid), .wb_next_pc(wb_next_pc),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- abstract model ----------------
  // Phases of one instruction's life; faults are terminal until reset.
  localparam int PH_START = 0, PH_ASK = 1, PH_AWAIT = 2, PH_OFFER = 3, PH_RUN = 4, PH_DEAD = 5;
  int          m_phase  = PH_START;
  int          m_waited = 0;
  logic [31:0] m_pc     = 32'h8000_0000;
  logic [31:0] m_ins    = 32'h0;
  logic [1:0]  m_cause  = 2'd0;
  int          m_accepts = 0;
  int          dut_accepts = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= PH_START;
      m_waited <= 0;
      m_pc     <= 32'h8000_0000;
      m_ins    <= 32'h0;
      m_cause  <= 2'd0;
    end else begin
      case (m_phase)
        PH_START: m_phase <= PH_ASK;
        PH_ASK: if (imem_req_ready) begin
          m_phase   <= PH_AWAIT;
          m_waited  <= 0;
          m_accepts <= m_accepts + 1;
        end
        PH_AWAIT: begin
          m_waited <= m_waited + 1;
          if (imem_rsp_valid && !imem_rsp_err) begin
            m_ins <= imem_rsp_data; m_phase <= PH_OFFER;
          end else if (imem_rsp_valid) begin
            m_phase <= PH_DEAD; m_cause <= 2'd1;
          end else if (m_waited + 1 >= int'(TMO)) begin
            m_phase <= PH_DEAD; m_cause <= 2'd2;
          end
        end
        PH_OFFER: if (idu_ready) m_phase <= PH_RUN;
        PH_RUN: if (wb_valid) begin
          if (wb_next_pc % 4 == 0) begin
            m_pc <= wb_next_pc; m_phase <= PH_ASK;
          end else begin
            m_phase <= PH_DEAD; m_cause <= 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready) dut_accepts <= dut_accepts + 1;
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_req_valid", 32'(imem_req_valid), 32'(m_phase == PH_ASK));
    chk("m_req_addr",  imem_req_addr, m_pc);
    chk("m_pc",        pc, m_pc);
    chk("m_ifu_valid", 32'(ifu_valid), 32'(m_phase == PH_OFFER));
    chk("m_real_ins",  real_ins, m_ins);
    chk("m_fault",     32'(fetch_fault), 32'(m_phase == PH_DEAD));
    chk("m_cause",     32'(fault_cause), 32'(m_cause));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    idu_ready = 1'b0; wb_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    tick(); tick();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_ins", real_ins, 32'h0);
    chk("rst_req", 32'(imem_req_valid), 32'd0);
    chk("rst_valid", 32'(ifu_valid), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);

    // Best-case first fetch
    imem_req_ready = 1'b1; rst = 1'b0;
    tick();
    chk("c1_req", 32'(imem_req_valid), 32'd1);
    chk("c1_addr", imem_req_addr, 32'h8000_0000);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0413;
    chk("c2_valid", 32'(ifu_valid), 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    chk("c3_valid", 32'(ifu_valid), 32'd1);
    chk("c3_ins", real_ins, 32'h0000_0413);

    // Decoder stall, with a write-back pulse that must be ignored in HOLD
    wb_valid = 1'b1; wb_next_pc = 32'h8000_0012;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", 32'(ifu_valid), 32'd1);
      chk("stall_ins", real_ins, 32'h0000_0413);
    end
    wb_valid = 1'b0; idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    chk("exec_valid", 32'(ifu_valid), 32'd0);
    chk("exec_nofault", 32'(fetch_fault), 32'd0);

    // Stale response during EXEC is discarded
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF;
    tick(); tick();
    imem_rsp_valid = 1'b0;
    chk("exec_stale_ins", real_ins, 32'h0000_0413);

    wb_valid = 1'b1; wb_next_pc = 32'h8000_0010;
    tick();
    wb_valid = 1'b0;
    chk("wb_req", 32'(imem_req_valid), 32'd1);
    chk("wb_addr", imem_req_addr, 32'h8000_0010);

    // Request stall: address held, exactly one accept
    acc0 = dut_accepts;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstall_req", 32'(imem_req_valid), 32'd1);
      chk("rstall_addr", imem_req_addr, 32'h8000_0010);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("one_accept", 32'(dut_accepts), 32'(acc0 + 1));
    chk("after_accept_req", 32'(imem_req_valid), 32'd0);

    // Response on the last allowed WAIT cycle wins over timeout
    tick(); tick(); tick();
    chk("w4_nofault", 32'(fetch_fault), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    tick();
    imem_rsp_valid = 1'b0;
    chk("late_rsp_nofault", 32'(fetch_fault), 32'd0);
    chk("late_rsp_valid", 32'(ifu_valid), 32'd1);
    chk("late_rsp_ins", real_ins, 32'h0010_0093);

    // Access error
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
    wb_valid = 1'b1; wb_next_pc = 32'h8000_0020; tick(); wb_valid = 1'b0;
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    chk("err_fault", 32'(fetch_fault), 32'd1);
    chk("err_cause", 32'(fault_cause), 32'd1);
    imem_req_ready = 1'b1; tick(); tick(); imem_req_ready = 1'b0;
    chk("err_absorb_req", 32'(imem_req_valid), 32'd0);
    chk("err_absorb_fault", 32'(fetch_fault), 32'd1);

    // Timeout after exactly TMO silent WAIT cycles
    restart();
    imem_req_ready = 1'b1; tick(); tick(); imem_req_ready = 1'b0;
    tick(); tick(); tick();
    chk("tmo_not_yet", 32'(fetch_fault), 32'd0);
    tick();
    chk("tmo_fault", 32'(fetch_fault), 32'd1);
    chk("tmo_cause", 32'(fault_cause), 32'd2);

    // Misaligned next PC
    restart();
    imem_req_ready = 1'b1; tick(); tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013; tick(); imem_rsp_valid = 1'b0;
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
    wb_valid = 1'b1; wb_next_pc = 32'h8000_0012; tick(); wb_valid = 1'b0;
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_cause", 32'(fault_cause), 32'd3);
    chk("mis_pc", pc, 32'h8000_0000);
    acc0 = dut_accepts;
    imem_req_ready = 1'b1; tick(); tick(); imem_req_ready = 1'b0;
    chk("mis_no_req", 32'(dut_accepts), 32'(acc0));

    // Reset in the middle of WAIT, then a stale response
    restart();
    imem_req_ready = 1'b1; tick(); tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013; tick(); imem_rsp_valid = 1'b0;
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
    wb_valid = 1'b1; wb_next_pc = 32'h8000_0040; tick(); wb_valid = 1'b0;
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    tick();
    chk("pre_rst_pc", pc, 32'h8000_0040);
    rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h8000_0000);
    chk("arst_ins", real_ins, 32'h0);
    chk("arst_req", 32'(imem_req_valid), 32'd0);
    chk("arst_fault", 32'(fetch_fault), 32'd0);
    tick();
    rst = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick(); tick();
    imem_rsp_valid = 1'b0;
    chk("stale_valid", 32'(ifu_valid), 32'd0);
    chk("stale_ins", real_ins, 32'h0);
    chk("restart_addr", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093; tick(); imem_rsp_valid = 1'b0;
    chk("restart_valid", 32'(ifu_valid), 32'd1);
    chk("restart_ins", real_ins, 32'h0000_0093);

    tick();
    chk("accept_total", 32'(dut_accepts), 32'(m_accepts));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
